rsa_modexp_unit: RTL and testbench

- Parametrised, handshake-driven modular exponentiation engine: computes C = P^E mod M with radix-2 Montgomery multiplication.
- Successor to the fixed-width RSA datapath:
  - Width and exponent length are independent parameters.
  - Adds start/busy/done handshake, abort, operand error detection and early exit on exhausted exponent bits.
- Sits between the register/SPI front-end (operands, Montgomery constant) and the result readback path.

---
 rtl/rsa_modexp_unit_if.sv | 27 ++
 rtl/rsa_modexp_unit.sv | 144 ++++++++++++++
 tb/tb_rsa_modexp_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_unit_if.sv
// Operand/handshake bundle for rsa_modexp_unit; the front-end drives the master side.
interface rsa_modexp_unit_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EXP_WIDTH = 8
);
  logic                 en;
  logic                 start;
  logic                 abort;
  logic [WIDTH-1:0]     P;
  logic [EXP_WIDTH-1:0] E;
  logic [WIDTH-1:0]     M;
  logic [WIDTH-1:0]     Const;
  logic [WIDTH-1:0]     C;
  logic                 busy;
  logic                 eoc;
  logic                 err;

  modport master (
    output en, start, abort, P, E, M, Const,
    input  C, busy, eoc, err
  );

  modport slave (
    input  en, start, abort, P, E, M, Const,
    output C, busy, eoc, err
  );
endinterface

// File: rtl/rsa_modexp_unit.sv
// Modular exponentiation C = P^E mod M using two parallel bit-serial radix-2
// Montgomery multipliers, right-to-left binary exponent scan with early exit.
module rsa_modexp_unit #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EXP_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  rsa_modexp_unit_if.slave bus
);
  localparam int unsigned N  = WIDTH + 2;
  localparam int unsigned CW = $clog2(N);
  localparam logic [N-1:0]  ONE_N    = N'(1);
  localparam logic [CW-1:0] LAST_CYC = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, LOAD, PRE, LOOP, POST, FINAL, DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     p_q, m_q, k_q, c_q;
  logic [EXP_WIDTH-1:0] e_q;
  logic                 err_q;
  logic [N-1:0]         x_q, y_q;
  logic [N:0]           s0_q, s1_q;
  logic [CW-1:0]        cyc_q;

  logic [N-1:0]         m_n, a0, b0, a1, b1;
  logic [N:0]           s0_nxt, s1_nxt;
  logic                 last, accept, bad_op, mul_act;
  logic [WIDTH-1:0]     c_fin;

  // One Montgomery step: S <- (S + a*B + q*M) / 2, q chosen to make the sum even.
  function automatic logic [N:0] mmm_step(input logic [N:0] s, input logic a,
                                          input logic [N-1:0] b, input logic [N-1:0] m);
    logic [N+1:0] t;
    t = {1'b0, s} + (a ? {2'b00, b} : '0);
    if (t[0]) t = t + {2'b00, m};
    return t[N+1:1];
  endfunction

  assign m_n     = {2'b00, m_q};
  assign last    = (cyc_q == LAST_CYC);
  assign accept  = (state_q == IDLE) && bus.start && !bus.abort;
  assign bad_op  = !m_q[0] || (p_q >= m_q);
  assign mul_act = (state_q == PRE) || (state_q == LOOP) || (state_q == POST);

  // Unit 0 owns X, unit 1 owns Y; operands stay constant for a whole multiply.
  always_comb begin
    a0 = x_q;
    b0 = x_q;
    a1 = y_q;
    b1 = x_q;
    if (state_q == PRE) begin
      a0 = {2'b00, p_q};
      b0 = {2'b00, k_q};
      a1 = ONE_N;
      b1 = {2'b00, k_q};
    end else if (state_q == POST) begin
      b1 = ONE_N;
    end
    s0_nxt = mmm_step((cyc_q == '0) ? '0 : s0_q, a0[cyc_q], b0, m_n);
    s1_nxt = mmm_step((cyc_q == '0) ? '0 : s1_q, a1[cyc_q], b1, m_n);
    c_fin  = (y_q >= m_n) ? WIDTH'(y_q - m_n) : y_q[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = LOAD;
      LOAD:  state_d = bad_op ? DONE : PRE;
      PRE:   if (last) state_d = (e_q == '0) ? POST : LOOP;
      LOOP:  if (last && ((e_q >> 1) == '0)) state_d = POST;
      POST:  if (last) state_d = FINAL;
      FINAL: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort && (state_q != IDLE)) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst)         state_q <= IDLE;
    else if (bus.en) state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q   <= '0;
      m_q   <= '0;
      k_q   <= '0;
      e_q   <= '0;
      c_q   <= '0;
      err_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      s0_q  <= '0;
      s1_q  <= '0;
      cyc_q <= '0;
    end else if (bus.en) begin
      if (accept) begin
        p_q <= bus.P;
        e_q <= bus.E;
        m_q <= bus.M;
        k_q <= bus.Const;
      end
      if (mul_act && !bus.abort) begin
        cyc_q <= last ? '0 : cyc_q + 1'b1;
        s0_q  <= s0_nxt;
        s1_q  <= s1_nxt;
      end else begin
        cyc_q <= '0;
      end
      // Exponent is consumed by shifting, so bit i is always e_q[0].
      if (last && !bus.abort) begin
        unique case (state_q)
          PRE: begin
            x_q <= s0_nxt[N-1:0];
            y_q <= s1_nxt[N-1:0];
          end
          LOOP: begin
            x_q <= s0_nxt[N-1:0];
            if (e_q[0]) y_q <= s1_nxt[N-1:0];
            e_q <= e_q >> 1;
          end
          POST:    y_q <= s1_nxt[N-1:0];
          default: ;
        endcase
      end
      if (!bus.abort) begin
        if ((state_q == LOAD) && bad_op) begin
          c_q   <= '0;
          err_q <= 1'b1;
        end else if (state_q == FINAL) begin
          c_q   <= c_fin;
          err_q <= 1'b0;
        end
      end
    end
  end

  assign bus.C    = c_q;
  assign bus.err  = err_q;
  assign bus.eoc  = (state_q == DONE);
  assign bus.busy = (state_q != IDLE) && (state_q != DONE);
endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Directed bench for rsa_modexp_unit: hand-computed results and cycle latencies.
module tb_rsa_modexp_unit;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   t0  = 0;
  int   tests = 0;
  int   fails = 0;
  logic [255:0] en_low_mask;
  logic [255:0] start_mask;

  rsa_modexp_unit_if #(.WIDTH(8), .EXP_WIDTH(8)) bus ();

  rsa_modexp_unit #(.WIDTH(8), .EXP_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] p, input logic [7:0] e,
                          input logic [7:0] m, input logic [7:0] k);
    @(negedge clk);
    bus.P     = p;
    bus.E     = e;
    bus.M     = m;
    bus.Const = k;
    bus.start = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_until(input int d);
    while (cyc - t0 < d) @(negedge clk);
  endtask

  // Runs one computation; en/start disturbances come from the masks, indexed by cycle offset.
  task automatic run_vec(input string tag, input logic [7:0] p, input logic [7:0] e,
                         input logic [7:0] m, input logic [7:0] k,
                         input int exp_c, input int exp_err, input int exp_lat);
    int  lat;
    int  d;
    bit  seen;
    bit  busy_ok;
    lat = -1;
    seen = 1'b0;
    busy_ok = 1'b1;
    do_start(p, e, m, k);
    for (int i = 0; i < 250 && !seen; i++) begin
      @(negedge clk);
      d = cyc - t0;
      if (bus.eoc === 1'b1) begin
        seen = 1'b1;
        lat = d;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
      end else if (bus.busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
      bus.start = (d < 256) ? start_mask[d] : 1'b0;
      bus.en    = (d < 256) ? !en_low_mask[d] : 1'b1;
      if (!seen) bus.P = bus.P + 8'd3;
    end
    bus.start = 1'b0;
    bus.en    = 1'b1;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " C"}, {24'd0, bus.C}, exp_c);
    check({tag, " err"}, {31'd0, bus.err}, exp_err);
    check({tag, " busy window"}, {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    check({tag, " eoc single"}, {31'd0, bus.eoc}, 32'd0);
    check({tag, " busy after"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " C held"}, {24'd0, bus.C}, exp_c);
    en_low_mask = '0;
    start_mask  = '0;
  endtask

  initial begin
    int eoc_cnt;
    en_low_mask = '0;
    start_mask  = '0;
    bus.en    = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.P     = '0;
    bus.E     = '0;
    bus.M     = '0;
    bus.Const = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset C", {24'd0, bus.C}, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset eoc", {31'd0, bus.eoc}, 32'd0);
    check("reset err", {31'd0, bus.err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 4^13 mod 253 = 108, k=4 -> 3 + 6*10 cycles
    run_vec("main", 8'd4, 8'd13, 8'd253, 8'd144, 108, 0, 63);
    run_vec("exp0", 8'd5, 8'd0, 8'd253, 8'd144, 1, 0, 23);
    // 254 = -1 mod 255, odd power -> 254, k=8
    run_vec("expmax", 8'd254, 8'd255, 8'd255, 8'd16, 254, 0, 103);
    run_vec("even M", 8'd4, 8'd13, 8'd100, 8'd0, 0, 1, 2);
    run_vec("P>=M", 8'd200, 8'd13, 8'd199, 8'd0, 0, 1, 2);

    do_start(8'd4, 8'd13, 8'd253, 8'd144);
    @(negedge clk);
    bus.start = 1'b0;
    wait_until(30);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort eoc", {31'd0, bus.eoc}, 32'd0);
    eoc_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.eoc === 1'b1) eoc_cnt++;
    end
    check("abort no eoc", eoc_cnt, 32'd0);
    check("abort C held", {24'd0, bus.C}, 32'd0);
    run_vec("after abort", 8'd4, 8'd13, 8'd253, 8'd144, 108, 0, 63);

    en_low_mask[3]  = 1'b1;
    en_low_mask[9]  = 1'b1;
    en_low_mask[17] = 1'b1;
    en_low_mask[18] = 1'b1;
    en_low_mask[30] = 1'b1;
    en_low_mask[44] = 1'b1;
    en_low_mask[58] = 1'b1;
    run_vec("en gaps", 8'd4, 8'd13, 8'd253, 8'd144, 108, 0, 70);

    start_mask[5]  = 1'b1;
    start_mask[40] = 1'b1;
    run_vec("restart busy", 8'd4, 8'd13, 8'd253, 8'd144, 108, 0, 63);

    do_start(8'd4, 8'd13, 8'd253, 8'd144);
    @(negedge clk);
    bus.start = 1'b0;
    wait_until(20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst C", {24'd0, bus.C}, 32'd0);
    check("midrst busy", {31'd0, bus.busy}, 32'd0);
    check("midrst eoc", {31'd0, bus.eoc}, 32'd0);
    check("midrst err", {31'd0, bus.err}, 32'd0);
    run_vec("after rst", 8'd5, 8'd0, 8'd253, 8'd144, 1, 0, 23);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
